// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and types for the IF fetch stage
package if_fetch_unit_pkg;

  localparam int IF_TO_ID_WD          = 35;
  localparam int IF_TO_ID_PC_LSB      = 0;
  localparam int IF_TO_ID_CE_BIT      = 32;
  localparam int IF_TO_ID_DISCARD_BIT = 33;
  localparam int IF_TO_ID_KILL_BIT    = 34;

  localparam int BR_WD    = 33;
  localparam int BR_E_BIT = 32;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic        slot0_kill;
    logic        discard;
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  typedef enum logic [2:0] {
    SRC_FLUSH,
    SRC_BR,
    SRC_PEND,
    SRC_HOLD,
    SRC_SEQ
  } pc_src_e;

  function automatic logic [31:0] align8(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// rtl/fetch_redirect_buf.sv - pending-redirect holder and next-PC priority mux
module fetch_redirect_buf
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        br_e,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_q,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] redirect_pc;
  pc_src_e     src;

  always_comb begin
    redirect    = flush | br_e;
    redirect_pc = flush ? new_pc : br_target;

    if (flush)         src = SRC_FLUSH;
    else if (br_e)     src = SRC_BR;
    else if (pend_v_q) src = SRC_PEND;
    else if (hold)     src = SRC_HOLD;
    else               src = SRC_SEQ;

    case (src)
      SRC_FLUSH: next_pc = new_pc;
      SRC_BR:    next_pc = br_target;
      SRC_PEND:  next_pc = pend_pc_q;
      SRC_HOLD:  next_pc = pc_q;
      default:   next_pc = align8(pc_q) + 32'd8;
    endcase

    // The most recent redirect seen while held is the one replayed on release.
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    if (!hold) begin
      pend_v_d = 1'b0;
    end else if (redirect) begin
      pend_v_d  = 1'b1;
      pend_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - dual-issue instruction fetch stage: PC, SRAM request, IF->ID bus
module if_fetch_unit #(
  parameter int          STALL_WD = 6,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [STALL_WD-1:0]                    stall,
  input  logic                                   flush,
  input  logic [31:0]                            new_pc,
  input  logic [if_fetch_unit_pkg::BR_WD-1:0]    br_bus,
  input  logic                                   fifo_full,
  output logic                                   inst_sram_en,
  output logic [7:0]                             inst_sram_wen,
  output logic [31:0]                            inst_sram_addr,
  output logic [if_fetch_unit_pkg::IF_TO_ID_WD-1:0] if_to_id_bus
);

  import if_fetch_unit_pkg::STOP;
  import if_fetch_unit_pkg::BR_E_BIT;
  import if_fetch_unit_pkg::if_to_id_t;
  import if_fetch_unit_pkg::align8;

  logic        hold;
  logic        mux_hold;
  logic        br_e;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        redirect;

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        slot0_kill_q, slot0_kill_d;
  logic        discard_q, discard_d;

  if_to_id_t   bus;
  logic        unused_stall;

  assign unused_stall = ^stall[STALL_WD-1:1];

  assign hold      = (stall[0] == STOP) | fifo_full;
  assign br_e      = br_bus[BR_E_BIT];
  assign br_target = br_bus[31:0];

  // Reset behaves like a hold for the address mux so the request bus shows pc_q.
  assign mux_hold = hold | rst;

  fetch_redirect_buf u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .hold      (mux_hold),
    .flush     (flush),
    .new_pc    (new_pc),
    .br_e      (br_e),
    .br_target (br_target),
    .pc_q      (pc_q),
    .next_pc   (next_pc),
    .redirect  (redirect)
  );

  always_comb begin
    pc_d         = pc_q;
    ce_d         = ce_q;
    slot0_kill_d = slot0_kill_q;
    discard_d    = discard_q;
    if (!hold) begin
      pc_d         = next_pc;
      ce_d         = 1'b1;
      slot0_kill_d = next_pc[2];
      discard_d    = 1'b0;
    end else if (redirect) begin
      // The pair sitting on the bus is now wrong-path; ID must drop it.
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC - 32'd8;
      ce_q         <= 1'b0;
      slot0_kill_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      slot0_kill_q <= slot0_kill_d;
      discard_q    <= discard_d;
    end
  end

  always_comb begin
    bus.slot0_kill = slot0_kill_q;
    bus.discard    = discard_q;
    bus.ce         = ce_q;
    bus.pc         = ce_q ? pc_q : 32'd0;
  end

  assign if_to_id_bus   = bus;
  assign inst_sram_en   = ~rst & ~hold;
  assign inst_sram_wen  = 8'h00;
  assign inst_sram_addr = align8(next_pc);

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [32:0] br_bus;
  logic        fifo_full;
  logic        inst_sram_en;
  logic [7:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [34:0] if_to_id_bus;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_unit #(
    .STALL_WD (6),
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .br_bus         (br_bus),
    .fifo_full      (fifo_full),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .if_to_id_bus   (if_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [34:0] mk_bus(input logic k, input logic d, input logic c,
                                         input logic [31:0] pc);
    return {k, d, c, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    stall     = 6'd0;
    flush     = 1'b0;
    new_pc    = 32'd0;
    br_bus    = 33'd0;
    fifo_full = 1'b0;
    tick();
    tick();

    chk("rst_en",   {63'd0, inst_sram_en}, 64'd0);
    chk("rst_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFBF_FFF8});
    chk("rst_bus",  {29'd0, if_to_id_bus}, 64'd0);
    chk("wen",      {56'd0, inst_sram_wen}, 64'd0);

    rst = 1'b0;
    settle();
    chk("c1_en",   {63'd0, inst_sram_en}, 64'd1);
    chk("c1_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0000});
    tick();
    chk("c2_bus",  {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0000)});
    chk("c2_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0008});
    tick();
    chk("c3_bus",  {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0008)});
    tick();
    chk("c4_bus",  {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0010)});

    br_bus = {1'b1, 32'hBFC0_0104};
    settle();
    chk("br_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0100});
    chk("br_en",   {63'd0, inst_sram_en}, 64'd1);
    tick();
    br_bus = 33'd0;
    settle();
    chk("br_bus",  {29'd0, if_to_id_bus}, {29'd0, mk_bus(1, 0, 1, 32'hBFC0_0104)});
    chk("br_seq_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0108});
    tick();
    chk("br_seq_bus", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0108)});

    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0200};
    settle();
    chk("st_en1", {63'd0, inst_sram_en}, 64'd0);
    tick();
    br_bus = 33'd0;
    settle();
    chk("st_bus1", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 1, 1, 32'hBFC0_0108)});
    chk("st_en2",  {63'd0, inst_sram_en}, 64'd0);
    tick();
    chk("st_bus2", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 1, 1, 32'hBFC0_0108)});
    tick();
    chk("st_bus3", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 1, 1, 32'hBFC0_0108)});
    stall = 6'd0;
    settle();
    chk("st_rel_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0200});
    chk("st_rel_en",   {63'd0, inst_sram_en}, 64'd1);
    tick();
    chk("st_rel_bus",  {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0200)});

    flush  = 1'b1;
    new_pc = 32'hBFC0_0380;
    br_bus = {1'b1, 32'hBFC0_0500};
    settle();
    chk("fl_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0380});
    tick();
    flush  = 1'b0;
    br_bus = 33'd0;
    settle();
    chk("fl_bus",  {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0380)});

    fifo_full = 1'b1;
    settle();
    chk("ff_en0", {63'd0, inst_sram_en}, 64'd0);
    tick();
    chk("ff_bus1", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0380)});
    tick();
    chk("ff_bus2", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0380)});
    chk("ff_en2",  {63'd0, inst_sram_en}, 64'd0);
    fifo_full = 1'b0;
    settle();
    chk("ff_rel_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0388});
    chk("ff_rel_en",   {63'd0, inst_sram_en}, 64'd1);
    tick();
    chk("ff_rel_bus",  {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0388)});

    flush  = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    settle();
    chk("wrap_addr0", {32'd0, inst_sram_addr}, {32'd0, 32'hFFFF_FFF8});
    tick();
    flush = 1'b0;
    settle();
    chk("wrap_bus", {29'd0, if_to_id_bus}, {29'd0, mk_bus(1, 0, 1, 32'hFFFF_FFFC)});
    chk("wrap_addr1", {32'd0, inst_sram_addr}, 64'd0);
    tick();
    chk("wrap_bus2", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'h0000_0000)});

    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0700};
    tick();
    br_bus = 33'd0;
    flush  = 1'b1;
    new_pc = 32'hBFC0_0800;
    tick();
    flush = 1'b0;
    stall = 6'd0;
    settle();
    chk("ovr_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0800});
    tick();
    chk("ovr_bus", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0800)});

    stall  = 6'b000001;
    br_bus = {1'b1, 32'hBFC0_0600};
    tick();
    br_bus = 33'd0;
    rst    = 1'b1;
    tick();
    chk("rst2_bus", {29'd0, if_to_id_bus}, 64'd0);
    chk("rst2_en",  {63'd0, inst_sram_en}, 64'd0);
    rst   = 1'b0;
    stall = 6'd0;
    settle();
    chk("rst2_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0000});
    chk("rst2_en1",  {63'd0, inst_sram_en}, 64'd1);
    tick();
    chk("rst2_bus1", {29'd0, if_to_id_bus}, {29'd0, mk_bus(0, 0, 1, 32'hBFC0_0000)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
